// File: rtl/mod_updown_counter.sv
// Up/down modulo counter with run-time limit, parallel load, wrap/saturate mode,
// registered terminal-count pulse and sticky overflow flag.
module mod_updown_counter #(
    parameter int unsigned WIDTH   = 7,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat,
    input  logic [WIDTH-1:0] max_val,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] W_RST = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] W_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    logic [WIDTH-1:0] w_count_nxt;
    logic             w_tc_nxt;
    logic             w_ovf_set;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;

    assign w_inc = r_count + W_ONE;
    assign w_dec = r_count - W_ONE;

    always_comb begin
        w_count_nxt = r_count;
        w_tc_nxt    = 1'b0;
        w_ovf_set   = 1'b0;
        if (load) begin
            w_count_nxt = (load_val > max_val) ? max_val : load_val;
        end else if (en) begin
            if (up_dn) begin
                if (r_count < max_val) begin
                    w_count_nxt = w_inc;
                    w_tc_nxt    = (w_inc == max_val);
                end else begin
                    // At or above the limit (including after a max_val reduction).
                    w_count_nxt = sat ? max_val : '0;
                    w_ovf_set   = 1'b1;
                end
            end else begin
                if (r_count > max_val) begin
                    w_count_nxt = max_val;
                    w_tc_nxt    = 1'b1;
                end else if (r_count != '0) begin
                    w_count_nxt = w_dec;
                    w_tc_nxt    = (w_dec == '0);
                end else begin
                    w_count_nxt = sat ? '0 : max_val;
                    w_ovf_set   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= W_RST;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
            // A set in the same cycle as a clear takes precedence.
            r_ovf   <= w_ovf_set | (r_ovf & ~ovf_clr);
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter: driver queues hand-computed expectations,
// monitor pops and compares one entry per clock after the active edge.
module tb_mod_updown_counter;

    localparam int unsigned WIDTH = 7;

    logic             clk;
    logic             rst;
    logic             en;
    logic             up_dn;
    logic             sat;
    logic [WIDTH-1:0] max_val;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             ovf_clr;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] cnt;
        logic             tc;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    mod_updown_counter #(
        .WIDTH  (WIDTH),
        .RST_VAL(0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .up_dn   (up_dn),
        .sat     (sat),
        .max_val (max_val),
        .load    (load),
        .load_val(load_val),
        .ovf_clr (ovf_clr),
        .count   (count),
        .tc      (tc),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus on the falling edge and queue the state expected after the next rise.
    task automatic vec(input string nm, input logic i_rst, input logic i_load, input int i_lval,
                       input logic i_en, input logic i_up, input logic i_sat, input int i_max,
                       input logic i_clr, input int e_cnt, input logic e_tc, input logic e_ovf);
        exp_t e;
        @(negedge clk);
        rst      = i_rst;
        load     = i_load;
        load_val = WIDTH'(i_lval);
        en       = i_en;
        up_dn    = i_up;
        sat      = i_sat;
        max_val  = WIDTH'(i_max);
        ovf_clr  = i_clr;
        e.name   = nm;
        e.cnt    = WIDTH'(e_cnt);
        e.tc     = e_tc;
        e.ovf    = e_ovf;
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (count !== e.cnt || tc !== e.tc || ovf !== e.ovf) begin
                    n_miss++;
                    $display("FAIL %s: got count=%0d tc=%b ovf=%b, expected count=%0d tc=%b ovf=%b",
                             e.name, count, tc, ovf, e.cnt, e.tc, e.ovf);
                end
            end
        end
    end

    initial begin
        int budget;
        rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; up_dn = 1'b1;
        sat = 1'b0; max_val = '0; ovf_clr = 1'b0;

        //   name          rst ld lval en up sat max clr   cnt tc ovf
        vec("reset",       1, 0,   0, 0, 1, 0,   0, 0,    0, 0, 0);
        vec("reset2",      1, 1,  55, 1, 1, 0, 100, 0,    0, 0, 0);

        // Count 0..100 and wrap.
        for (int i = 1; i <= 100; i++)
            vec("up_count",    0, 0, 0, 1, 1, 0, 100, 0,  i, (i == 100), 0);
        vec("up_wrap",     0, 0,   0, 1, 1, 0, 100, 0,    0, 0, 1);
        vec("idle_clr",    0, 0,   0, 0, 1, 0, 100, 1,    0, 0, 0);

        // Load clamp, exact-limit load, saturated up hold.
        vec("load_clamp",  0, 1, 120, 1, 0, 0, 100, 0,  100, 0, 0);
        vec("load_exact",  0, 1, 100, 0, 1, 0, 100, 0,  100, 0, 0);
        vec("up_sat_hold", 0, 0,   0, 1, 1, 1, 100, 0,  100, 0, 1);
        vec("load_keepov", 0, 1,  42, 0, 1, 0, 100, 0,   42, 0, 1);

        // Down wrap with max_val=9, clear vs set in same cycle.
        vec("load1_clr",   0, 1,   1, 0, 0, 0,   9, 1,    1, 0, 0);
        vec("down_tc0",    0, 0,   0, 1, 0, 0,   9, 0,    0, 1, 0);
        vec("down_wrap",   0, 0,   0, 1, 0, 0,   9, 1,    9, 0, 1);
        vec("idle_clr2",   0, 0,   0, 0, 0, 0,   9, 1,    9, 0, 0);
        vec("down_step",   0, 0,   0, 1, 0, 0,   9, 0,    8, 0, 0);
        vec("idle_hold",   0, 0,   0, 0, 0, 0,   9, 0,    8, 0, 0);
        vec("load0",       0, 1,   0, 0, 0, 0,   9, 0,    0, 0, 0);
        vec("down_sat0",   0, 0,   0, 1, 0, 1,   9, 0,    0, 0, 1);

        // max_val reduced below the current count.
        vec("load50",      0, 1,  50, 0, 0, 0, 100, 1,   50, 0, 0);
        vec("down_oor",    0, 0,   0, 1, 0, 0,  20, 0,   20, 1, 0);
        vec("tc_drop",     0, 0,   0, 0, 0, 0,  20, 0,   20, 0, 0);
        vec("load50b",     0, 1,  50, 0, 0, 0, 100, 0,   50, 0, 0);
        vec("up_oor_wrap", 0, 0,   0, 1, 1, 0,  20, 0,    0, 0, 1);
        vec("load50c",     0, 1,  50, 0, 0, 0, 100, 1,   50, 0, 0);
        vec("up_oor_sat",  0, 0,   0, 1, 1, 1,  20, 0,   20, 0, 1);
        vec("load19",      0, 1,  19, 0, 1, 0,  20, 1,   19, 0, 0);
        vec("up_tc",       0, 0,   0, 1, 1, 0,  20, 0,   20, 1, 0);

        // Reset beats load and enable.
        vec("load37",      0, 1,  37, 0, 1, 0, 100, 1,   37, 0, 0);
        vec("up_ovf",      0, 0,   0, 1, 1, 1,  37, 0,   37, 0, 1);
        vec("rst_prio",    1, 1,  60, 1, 1, 0, 100, 0,    0, 0, 0);

        // max_val = 0: count pinned at 0.
        vec("max0_up",     0, 0,   0, 1, 1, 0,   0, 0,    0, 0, 1);
        vec("max0_up2",    0, 0,   0, 1, 1, 0,   0, 0,    0, 0, 1);
        vec("max0_clr",    0, 0,   0, 0, 1, 0,   0, 1,    0, 0, 0);
        vec("max0_idle",   0, 0,   0, 0, 1, 0,   0, 0,    0, 0, 0);
        vec("max0_down",   0, 0,   0, 1, 0, 0,   0, 0,    0, 0, 1);
        vec("max0_load",   0, 1,   5, 0, 1, 0,   0, 0,    0, 0, 1);

        @(negedge clk);
        en = 1'b0; load = 1'b0; rst = 1'b0; ovf_clr = 1'b0;
        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
